// File: rtl/fnv_hash_sequencer.sv
// Command sequencer around an external FNV-1a 32-bit hasher: parses clear/hash/read
// commands from a byte stream and returns the snapshotted hash MSB-first.
module fnv_hash_sequencer #(
  parameter logic [7:0] CmdClear = 8'h01,
  parameter logic [7:0] CmdHash  = 8'h02,
  parameter logic [7:0] CmdRead  = 8'h03
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        hash_clear,
  output logic        hash_enable,
  output logic [7:0]  hash_byte,
  input  logic [31:0] hash_in,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    SNAP,
    SEND
  } state_t;

  state_t      state;
  logic [7:0]  remaining;
  logic [31:0] shift;
  logic [1:0]  index;
  logic        rx_fire;
  logic        tx_fire;

  // Reset gates rx_ready so nothing is accepted while the block is held.
  assign rx_ready = !reset && (state == IDLE || state == LEN || state == DATA);
  assign busy     = (state != IDLE);
  assign tx_byte  = shift[31:24];
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      remaining   <= 8'd0;
      shift       <= 32'd0;
      index       <= 2'd0;
      tx_valid    <= 1'b0;
      hash_clear  <= 1'b0;
      hash_enable <= 1'b0;
      hash_byte   <= 8'd0;
      err         <= 1'b0;
    end else begin
      hash_clear  <= 1'b0;
      hash_enable <= 1'b0;
      hash_byte   <= 8'd0;
      case (state)
        IDLE: begin
          if (rx_fire) begin
            case (rx_byte)
              CmdClear: hash_clear <= 1'b1;
              CmdHash:  state <= LEN;
              CmdRead:  state <= SNAP;
              default:  err <= 1'b1;
            endcase
          end
        end
        LEN: begin
          if (rx_fire) begin
            remaining <= rx_byte;
            state     <= (rx_byte == 8'd0) ? IDLE : DATA;
          end
        end
        DATA: begin
          // Every byte here is payload, even if it looks like a command.
          if (rx_fire) begin
            hash_byte   <= rx_byte;
            hash_enable <= 1'b1;
            remaining   <= remaining - 8'd1;
            if (remaining == 8'd1) state <= IDLE;
          end
        end
        SNAP: begin
          shift    <= hash_in;
          index    <= 2'd0;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (tx_fire) begin
            shift <= {shift[23:0], 8'h00};
            index <= index + 2'd1;
            if (index == 2'd3) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
